// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/port types and default starvation bound for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} port_id_t;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data requests onto one single-port memory with data priority and bounded fetch starvation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int CW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  arb_state_t state, state_d;
  port_id_t win;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic drop_flag, grant, ack_i, ack_d, keep_i;
  always_comb begin
    win = d_req && (!if_req || starve_cnt < CW'(STARVE_MAX)) ? PORT_D : PORT_I;
    grant = state == IDLE && (if_req || d_req);
    ack_i = state == BUSY_I && mem_ack;
    ack_d = state == BUSY_D && mem_ack;
    keep_i = !(drop_flag || if_flush);
    starve_nxt = (win == PORT_D && if_req) ? (starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1) : '0;
    state_d = grant ? (win == PORT_D ? BUSY_D : BUSY_I) : (ack_i || ack_d) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      starve_cnt <= '0;
      drop_flag <= 1'b0;
      if_gnt <= 1'b0;
      d_gnt <= 1'b0;
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt <= grant && win == PORT_I;
      d_gnt <= grant && win == PORT_D;
      if_valid <= ack_i && keep_i;
      d_valid <= ack_d;
      drop_flag <= state == BUSY_I && !mem_ack && !keep_i;
      if (grant) begin
        mem_req <= 1'b1;
        mem_we <= win == PORT_D && d_we;
        mem_addr <= win == PORT_D ? d_addr : if_addr;
        starve_cnt <= starve_nxt;
        if (win == PORT_D) mem_wdata <= d_wdata;
      end
      if (ack_i || ack_d) mem_req <= 1'b0;
      if (ack_i && keep_i) if_rdata <= mem_rdata;
      if (ack_d && !mem_we) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter with directed corner cases
module tb_mem_port_arbiter;
  localparam int SM = 4;
  localparam logic [31:0] IBASE = 32'h40, DBASE = 32'h100;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  logic clk = 0, resetN = 1;
  logic if_req = 0, if_flush = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic z_if_req = 0, z_d_req = 0, z_mem_ack = 0;
  logic z_if_gnt, z_if_valid, z_d_gnt, z_d_valid, z_mem_req, z_mem_we;
  logic [31:0] z_if_rdata, z_d_rdata, z_mem_addr, z_mem_wdata;
  int checks = 0, failures = 0;
  logic [31:0] ref_m [logic [31:0]];
  logic [31:0] mm [logic [31:0]];
  logic [31:0] iq[$], dq[$];
  txn_t mq[$];
  logic [31:0] last_i = 0, last_d = 0, ie, de;
  bit mem_on = 1;
  int force_lat = 0, mlat, cnt = 0, zn, zt, n, t;
  txn_t me;
  logic [1:0] aexp;
  logic [9:0] seq;

  mem_port_arbiter #(.STARVE_MAX(SM)) u_dut (
    .clk(clk), .resetN(resetN),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  mem_port_arbiter #(.STARVE_MAX(0)) u_z (
    .clk(clk), .resetN(resetN),
    .if_req(z_if_req), .if_addr(IBASE), .if_flush(1'b0),
    .if_gnt(z_if_gnt), .if_valid(z_if_valid), .if_rdata(z_if_rdata),
    .d_req(z_d_req), .d_we(1'b0), .d_addr(DBASE), .d_wdata(32'h0),
    .d_gnt(z_d_gnt), .d_valid(z_d_valid), .d_rdata(z_d_rdata),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(32'h0), .mem_ack(z_mem_ack)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rst;
    chk("rst_ctl", {if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 resetN = 0;
    #1 chk_rst;
    @(negedge clk);
    @(negedge clk);
    resetN = 1;
    iq.delete(); dq.delete(); mq.delete();
    last_i = 0; last_d = 0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int off, input bit pre);
    int w;
    bit fl;
    @(negedge clk);
    if_req = 1; if_addr = a; if_flush = pre;
    iq.push_back(ref_m[a]);
    w = 0;
    do begin @(negedge clk); if_flush = 0; w++; end while (!if_gnt && w < 60);
    chk("if_gnt_seen", if_gnt, 1);
    if_req = 0; if_addr = $urandom;
    fl = 0;
    for (int k = 0; k < 60; k++) begin
      if_flush = (k == off);
      @(posedge clk);
      fl |= if_flush;
      if (mem_ack) break;
      @(negedge clk);
    end
    chk("if_ack_seen", mem_ack, 1);
    if (fl) void'(iq.pop_back());
    @(negedge clk);
    if_flush = 0;
    if (fl) chk("if_rdata_hold", if_rdata, last_i);
    w = 0;
    while (iq.size() != 0 && w < 60) begin @(negedge clk); w++; end
    chk("if_drain", iq.size(), 0);
  endtask

  task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd);
    int w;
    @(negedge clk);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    if (we) begin dq.push_back(last_d); ref_m[a] = wd; end
    else begin dq.push_back(ref_m[a]); last_d = ref_m[a]; end
    w = 0;
    do begin @(negedge clk); w++; end while (!d_gnt && w < 60);
    chk("d_gnt_seen", d_gnt, 1);
    d_req = 0; d_we = $urandom; d_addr = $urandom; d_wdata = $urandom;
    w = 0;
    while (dq.size() != 0 && w < 60) begin @(negedge clk); w++; end
    chk("d_drain", dq.size(), 0);
  endtask

  // memory emulation: random latency, checks each accepted transaction against the grant-time expectation
  initial forever begin
    @(negedge clk);
    if (mem_on) begin
      mem_ack = 0;
      if (mem_req) begin
        mlat = force_lat != 0 ? force_lat : int'($urandom_range(1, 3));
        repeat (mlat) @(negedge clk);
        if (resetN && mem_req) begin
          if (mq.size() == 0) chk("mem_txn_queued", mem_req, 0);
          else begin
            me = mq.pop_front();
            chk("mem_addr", mem_addr, me.addr);
            chk("mem_we", mem_we, me.we);
            if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
          end
          mem_rdata = mem_we ? $urandom : mm[mem_addr];
          if (mem_we) mm[mem_addr] = mem_wdata;
          mem_ack = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    z_mem_ack = z_mem_req && !z_mem_ack;
  end

  // arbitration model: requests as sampled on the grant edge decide the expected winner
  initial forever begin
    @(posedge clk);
    #1;
    if (!resetN) cnt = 0;
    else if (if_gnt || d_gnt) begin
      aexp = (d_req && (!if_req || cnt < SM)) ? 2'b01 : 2'b10;
      chk("arb_winner", {if_gnt, d_gnt}, aexp);
      if (d_gnt) begin
        cnt = if_req ? (cnt < SM ? cnt + 1 : SM) : 0;
        mq.push_back('{d_we, d_addr, d_wdata});
      end else begin
        cnt = 0;
        mq.push_back('{1'b0, if_addr, 32'h0});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (if_valid) begin
      if (iq.size() == 0) chk("if_spurious", if_valid, 0);
      else begin ie = iq.pop_front(); chk("if_rdata", if_rdata, ie); last_i = ie; end
    end
    if (d_valid) begin
      if (dq.size() == 0) chk("d_spurious", d_valid, 0);
      else begin de = dq.pop_front(); chk("d_rdata", d_rdata, de); end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref_m[IBASE + 4 * i] = $urandom; mm[IBASE + 4 * i] = ref_m[IBASE + 4 * i];
      ref_m[DBASE + 4 * i] = $urandom; mm[DBASE + 4 * i] = ref_m[DBASE + 4 * i];
    end
    #1 resetN = 0;
    do_reset;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_fetch(IBASE + 4 * $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 99, $urandom_range(0, 4) == 0);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_data($urandom_range(0, 1), DBASE + 4 * $urandom_range(0, 7), $urandom);
      end
      begin
        @(negedge clk);
        z_if_req = 1; z_d_req = 1;
        zn = 0; zt = 0;
        while (zn < 4 && zt < 100) begin
          @(negedge clk); zt++;
          if (z_if_gnt || z_d_gnt) begin chk("z_tie_to_fetch", {z_if_gnt, z_d_gnt}, 2'b10); zn++; end
        end
        chk("z_tie_count", zn, 4);
        z_if_req = 0; zt = 0;
        do begin @(negedge clk); zt++; end while (!(z_if_gnt || z_d_gnt) && zt < 100);
        chk("z_data_alone", {z_if_gnt, z_d_gnt}, 2'b01);
        z_d_req = 0;
      end
    join
    do_reset;
    force_lat = 2;
    ref_m[IBASE] = 32'h8C220004; mm[IBASE] = 32'h8C220004;
    @(negedge clk);
    if_req = 1; if_addr = IBASE;
    iq.push_back(32'h8C220004);
    @(negedge clk);
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    if_req = 0;
    repeat (3) @(negedge clk);
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_rdata", if_rdata, 32'h8C220004);
    force_lat = 0;
    do_data(1, 32'h100, 32'hDEADBEEF);
    do_data(0, 32'h100, 32'h0);
    force_lat = 2;
    do_fetch(IBASE + 8, 1, 0);
    do_fetch(32'h44, 99, 0);
    force_lat = 0;
    do_reset;
    @(negedge clk);
    if_req = 1; if_addr = IBASE; d_req = 1; d_we = 0; d_addr = DBASE;
    repeat (8) dq.push_back(ref_m[DBASE]);
    repeat (2) iq.push_back(ref_m[IBASE]);
    seq = 0; n = 0; t = 0;
    while (n < 10 && t < 300) begin
      @(negedge clk); t++;
      if (if_gnt || d_gnt) begin seq = {seq[8:0], if_gnt}; n++; end
    end
    if_req = 0; d_req = 0;
    chk("grant_order", seq, 10'b0000100001);
    t = 0;
    while (iq.size() + dq.size() != 0 && t < 100) begin @(negedge clk); t++; end
    chk("order_drain", iq.size() + dq.size(), 0);
    mem_on = 0; mem_ack = 0;
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = DBASE + 8;
    @(negedge clk);
    chk("rst_d_gnt", d_gnt, 1);
    d_req = 0;
    do_reset;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 0;
    chk("stray_no_dvalid", d_valid, 0);
    chk("stray_no_mem_req", mem_req, 0);
    mem_on = 1;
    do_data(0, DBASE + 8, 32'h0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the pipelined core.
- Serialises requests with a 3-state FSM and returns read data via registered valid pulses.
- Data port has priority; a bounded starvation counter guarantees fetch progress.
- Supports squashing an in-flight fetch on branch/jump redirect.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; 0 = fetch always wins ties

Ports:
clk  in  1  clock, rising edge
resetN  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt seen
if_addr  in  ADDR_W  fetch address; stable while if_req high
if_flush  in  1  squash pending fetch response (redirect)
if_gnt  out  1  one-cycle grant pulse to fetch
if_valid  out  1  one-cycle fetch data valid pulse
if_rdata  out  DATA_W  fetch data; held until next if_valid
d_req  in  1  data request; held until d_gnt seen
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle grant pulse to data port
d_valid  out  1  one-cycle completion pulse (loads and stores)
d_rdata  out  DATA_W  load data; unchanged on store completion
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, variable latency ≥1 cycle

Behaviour:
- Single clock domain (clk); reset is asynchronous, active-low (resetN).
- Reset:
  - FSM = IDLE; starve_cnt = 0; drop_flag = 0.
  - All outputs 0: gnt, valid, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE selection, sampled at each rising edge:
  - only d_req → BUSY_D
  - only if_req → BUSY_I
  - both and starve_cnt < STARVE_MAX → BUSY_D
  - both and starve_cnt ≥ STARVE_MAX → BUSY_I
  - neither → stay IDLE
- Grant edge actions:
  - Latch winner's addr (plus we/wdata for data; we = 0 for fetch) into mem_addr/mem_we/mem_wdata registers.
  - Set mem_req = 1.
  - Pulse the winner's gnt for exactly the next cycle.
- Handshake latency:
  - req sampled at edge N → gnt and mem_req high in cycle N+1.
  - Requester may drop req or change addr from cycle N+1 onward.
  - req high in BUSY states is ignored.
- BUSY_x:
  - mem_req and the mem_* registers stay constant until mem_ack is sampled high.
  - On that edge: mem_req → 0, FSM → IDLE, x_rdata ← mem_rdata (loads/fetches only), x_valid pulses for the next cycle.
  - A new grant can therefore be issued no earlier than one cycle after the ack cycle (one dead IDLE cycle).
  - Minimum request-to-valid latency is 3 cycles with single-cycle ack.
- Starvation counter:
  - D grant while if_req = 1 → starve_cnt+1, saturating at STARVE_MAX.
  - D grant while if_req = 0 → starve_cnt = 0.
  - Any I grant → starve_cnt = 0.
- Flush:
  - if_flush = 1 in any BUSY_I cycle, including the ack cycle, sets drop_flag.
  - At ack, if drop_flag or if_flush is set: no if_valid pulse, if_rdata unchanged, drop_flag cleared.
  - The memory transaction still completes.
  - if_flush in IDLE/BUSY_D has no effect; it does not cancel an unsampled if_req.
- mem_ack while IDLE is ignored, with no state change.
- Address low bits are passed through unmodified; no alignment check.
- resetN low mid-transaction:
  - Abandons the transaction immediately; mem_req drops asynchronously.
  - No valid pulse is generated.
  - A late mem_ack after reset release lands in IDLE and is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}
  - port_id_t enum {PORT_I, PORT_D}
  - default STARVE_MAX constant
- Single module; no sub-module. The starvation counter is ~10 lines inline.

Test Plan:
- Fetch only: if_req at edge 0, addr 0x40, mem_ack at cycle 3 with rdata 0x8C220004 → if_gnt in cycle 1, mem_addr 0x40, if_valid in cycle 4, if_rdata 0x8C220004.
- Simultaneous req, STARVE_MAX = 4, both held continuously → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I.
- Store: d_req, d_we = 1, addr 0x100, wdata 0xDEADBEEF → mem_we = 1 with correct addr/wdata; d_valid pulses; d_rdata keeps its previous value.
- Flush: fetch granted, if_flush pulsed one cycle before mem_ack → no if_valid, if_rdata unchanged; the next fetch to 0x44 completes normally.
- Reset in BUSY_D before ack → all outputs 0 immediately; a later stray mem_ack causes no d_valid; next d_req is served normally.
- STARVE_MAX = 0, both requesting → every tie goes to I; D is served only when if_req is low.
